link_frame_tx: RTL and testbench

Parametrised frame serializer for the board-to-board game link. It generalises the fixed 16-bit word multiplexer that streams player, ball and score state over UART. It snapshots CHANNELS state fields on a frame request and emits one self-delimiting byte frame to the UART byte transmitter: sync byte, sequence number, payload, then a check byte. It sits between game logic (ball, judge, player position) and the uart block, all in the 65 MHz pixel clock domain.

---
 rtl/link_pkg.sv | 21 ++
 rtl/link_chk_acc.sv | 50 +++++
 rtl/link_frame_tx.sv | 142 ++++++++++++++
 tb/tb_link_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the game-link frame transmitter and receiver.
// Holds the FSM state encoding, sync marker, frame length helper and CRC-8 polynomial.
package link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } link_state_e;

  localparam logic [7:0] LINK_SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] LINK_CRC8_POLY    = 8'h07;

  // sync + seq + two bytes per channel + check
  function automatic int link_frame_len(input int channels);
    return 2 * channels + 3;
  endfunction

endpackage

// File: rtl/link_chk_acc.sv
// Frame check accumulator over SEQ and DATA bytes.
// LINK_CRC8_EN selects CRC-8 (poly 0x07, init 0, MSB-first); otherwise a running XOR.
module link_chk_acc
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] data_byte,
  input  logic       enable,
  output logic [7:0] check
);

  logic [7:0] acc_q;
  logic [7:0] acc_upd;

`ifdef LINK_CRC8_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ LINK_CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  assign acc_upd = crc8_step(acc_q, data_byte);
`else
  assign acc_upd = acc_q ^ data_byte;
`endif

  // check already includes the byte accepted this cycle, so the caller can register it directly
  always_comb begin
    check = acc_q;
    if (clear) begin
      check = '0;
    end else if (enable) begin
      check = acc_upd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= check;
    end
  end

endmodule

// File: rtl/link_frame_tx.sv
// Game-link frame serializer: snapshots CHANNELS fields and streams sync, seq, payload, check.
// Check byte type is chosen by LINK_CRC8_EN (see link_chk_acc); frame format is identical in both modes.
//
// state | meaning
// IDLE  | waiting for frame_req or a pending request
// SYNC  | presenting the sync marker
// SEQ   | presenting the sequence number
// DATA  | presenting payload byte idx (high byte of each field first)
// CHK   | presenting the check byte
module link_frame_tx
  import link_pkg::*;
#(
  parameter int         CHANNELS  = 8,
  parameter int         FIELD_W   = 12,
  parameter logic [7:0] SYNC_BYTE = LINK_SYNC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*FIELD_W-1:0] fields,
  input  logic                        frame_req,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  drop_cnt
);

  localparam int IDX_W    = $clog2(2 * CHANNELS);
  localparam int LAST_IDX = link_frame_len(CHANNELS) - 4;

  link_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [7:0]                  seq_q, seq_d;
  logic                        pending_q, pending_d;
  logic [7:0]                  drop_d;
  logic [CHANNELS*FIELD_W-1:0] shadow_q, shadow_d;
  logic [7:0]                  tx_data_d;
  logic                        tx_valid_d, busy_d, frame_done_d;

  logic                        accept, start, last_idx;
  logic                        acc_clr, acc_en;
  logic [7:0]                  check;
  logic [FIELD_W-1:0]          field_sel;
  logic [15:0]                 data_word;

  assign accept   = tx_valid && tx_ready;
  assign start    = (state_q == ST_IDLE) && (frame_req || pending_q);
  assign last_idx = (idx_q == IDX_W'(LAST_IDX));

  link_chk_acc u_chk_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clr),
    .data_byte (tx_data),
    .enable    (acc_en),
    .check     (check)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      pending_q  <= 1'b0;
      drop_cnt   <= '0;
      shadow_q   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      pending_q  <= pending_d;
      drop_cnt   <= drop_d;
      shadow_q   <= shadow_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: if (start)  state_d = ST_SYNC;
      ST_SYNC: if (accept) state_d = ST_SEQ;
      ST_SEQ: begin
        if (accept) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (last_idx) state_d = ST_CHK;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      ST_CHK:  if (accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign field_sel = shadow_q[int'(idx_d >> 1) * FIELD_W +: FIELD_W];
  assign data_word = 16'(field_sel);

  always_comb begin
    seq_d     = seq_q;
    pending_d = pending_q;
    drop_d    = drop_cnt;
    shadow_d  = shadow_q;
    if (start) begin
      shadow_d  = fields;
      pending_d = 1'b0;
    end else if ((state_q != ST_IDLE) && frame_req) begin
      // one request may wait behind the current frame; any further ones are counted as dropped
      if (!pending_q)              pending_d = 1'b1;
      else if (drop_cnt != 8'hFF)  drop_d    = drop_cnt + 8'd1;
    end
    if ((state_q == ST_CHK) && accept) seq_d = seq_q + 8'd1;

    acc_clr      = start;
    acc_en       = accept && ((state_q == ST_SEQ) || (state_q == ST_DATA));
    frame_done_d = (state_q == ST_CHK) && accept;
    tx_valid_d   = (state_d != ST_IDLE);
    busy_d       = tx_valid_d;

    unique case (state_d)
      ST_SYNC: tx_data_d = SYNC_BYTE;
      ST_SEQ:  tx_data_d = seq_q;
      ST_DATA: tx_data_d = idx_d[0] ? data_word[7:0] : data_word[15:8];
      ST_CHK:  tx_data_d = check;
      default: tx_data_d = '0;
    endcase
  end

endmodule

// File: tb/tb_link_frame_tx.sv
// Self-checking bench for link_frame_tx (CHANNELS=2, FIELD_W=12) against a frame-level model.
module tb_link_frame_tx;

  localparam int CH   = 2;
  localparam int FW   = 12;
  localparam int FLEN = 2 * CH + 3;

  logic           clk;
  logic           rst;
  logic [CH*FW-1:0] fields;
  logic           frame_req;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           frame_done;
  logic [7:0]     drop_cnt;

  link_frame_tx #(.CHANNELS(CH), .FIELD_W(FW), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .fields     (fields),
    .frame_req  (frame_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] q[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (q[i]) begin
      c = c ^ q[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] chk_of(input logic [7:0] q[$]);
    logic [7:0] x;
`ifdef LINK_CRC8_EN
    x = crc8(q);
`else
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
`endif
    return x;
  endfunction

  // expected check byte for the fixed test fields {0x123, 0xABC} with a given seq
  function automatic logic [7:0] exp_chk(input logic [7:0] s);
`ifdef LINK_CRC8_EN
    logic [7:0] q[$];
    q = {s, 8'h01, 8'h23, 8'h0A, 8'hBC};
    return crc8(q);
`else
    return 8'h94 ^ s;
`endif
  endfunction

  // frame-level reference model
  logic [7:0] m_frame[$];
  int         m_pos;
  bit         m_busy, m_pend, m_done;
  int         m_drop;
  logic [7:0] m_seq;

  task automatic m_build();
    logic [7:0]  body[$];
    logic [15:0] w;
    body = {m_seq};
    for (int k = 0; k < CH; k++) begin
      w = 16'(fields[k*FW +: FW]);
      body.push_back(w[15:8]);
      body.push_back(w[7:0]);
    end
    m_frame = {8'hA5};
    foreach (body[i]) m_frame.push_back(body[i]);
    m_frame.push_back(chk_of(body));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_pend = 0; m_done = 0; m_drop = 0; m_seq = 8'h00; m_pos = 0;
      m_frame = {};
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (frame_req || m_pend) begin
          m_build();
          m_pend = 0;
          m_busy = 1;
          m_pos  = 0;
        end
      end else begin
        if (frame_req) begin
          if (!m_pend) m_pend = 1;
          else if (m_drop < 255) m_drop++;
        end
        if (tx_ready) begin
          m_pos++;
          if (m_pos == FLEN) begin
            m_busy = 0;
            m_done = 1;
            m_seq  = m_seq + 8'd1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("tx_valid", 32'(tx_valid), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_busy) check("tx_data", 32'(tx_data), 32'(m_frame[m_pos]));
  end

  // accepted-byte capture and frame counter from the DUT side
  logic [7:0] cap[$];
  int         done_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_cnt = 0;
    end else begin
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      if (frame_done) done_cnt++;
    end
  end

  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic send_frame(input string tag);
    int target;
    target = done_cnt + 1;
    pulse_req();
    wait_done(target, tag);
    tick();
  endtask

  task automatic check_fixed_frame(input string tag, input logic [7:0] s);
    logic [7:0] exp[$];
    exp = {8'hA5, s, 8'h01, 8'h23, 8'h0A, 8'hBC, exp_chk(s)};
    check({tag, "_len"}, 32'(cap.size()), 32'(FLEN));
    for (int i = 0; i < FLEN; i++) begin
      if (i < cap.size()) check($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp[i]));
    end
  endtask

  localparam logic [CH*FW-1:0] FIX_FIELDS = {12'hABC, 12'h123};

  initial begin
    logic [7:0] pin[$];
    int         t;

    rst       = 1'b0;
    frame_req = 1'b0;
    tx_ready  = 1'b1;
    fields    = FIX_FIELDS;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    pin = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc8_model_pin", 32'(crc8(pin)), 32'hF4);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);

    // basic and second frame
    cap = {};
    send_frame("basic");
    check_fixed_frame("basic", 8'h00);
    check("basic_done_count", 32'(done_cnt), 32'd1);
    cap = {};
    send_frame("second");
    check_fixed_frame("second", 8'h01);

    // backpressure
    cap = {};
    rand_ready = 1;
    send_frame("bp");
    rand_ready = 0;
    tx_ready   = 1'b1;
    check_fixed_frame("bp", 8'h02);

    // overrun: start + pending + dropped
    cap = {};
    t = done_cnt + 2;
    pulse_req();
    tick(); tick();
    pulse_req();
    tick(); tick();
    pulse_req();
    wait_done(t, "overrun");
    tick(); tick();
    check("overrun_drop", 32'(drop_cnt), 32'd1);
    check("overrun_bytes", 32'(cap.size()), 32'(2 * FLEN));
    if (cap.size() > FLEN) check("overrun_sync2", 32'(cap[FLEN]), 32'hA5);

    // snapshot: change fields mid-DATA
    cap = {};
    t = done_cnt + 1;
    pulse_req();
    tick(); tick();
    fields = '1;
    wait_done(t, "snap");
    tick();
    fields = FIX_FIELDS;
    check_fixed_frame("snap", 8'h05);

    // sequence wrap
    while (done_cnt < 256) send_frame("wrap_fill");
    cap = {};
    send_frame("wrap");
    check_fixed_frame("wrap", 8'h00);

    // drop counter saturation with the link stalled
    tx_ready = 1'b0;
    pulse_req();
    for (int i = 0; i < 300; i++) begin
      pulse_req();
      tick();
    end
    check("drop_saturate", 32'(drop_cnt), 32'd255);
    t = done_cnt + 2;
    tx_ready = 1'b1;
    wait_done(t, "sat_drain");
    tick(); tick();

    // reset mid-DATA
    pulse_req();
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    cap = {};
    send_frame("post_rst");
    check_fixed_frame("post_rst", 8'h00);

    // randomized traffic
    rand_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) fields = CH*FW'($urandom);
      frame_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    frame_req  = 1'b0;
    rand_ready = 0;
    tx_ready   = 1'b1;
    repeat (60) tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
